// File: rtl/field_time_entry_pkg.sv
// field_time_entry_pkg: shared state encoding, BCD range limits and helpers for time entry
package field_time_entry_pkg;

    typedef enum logic [1:0] {S_IDLE, S_ENTRY, S_DONE} state_e;

    localparam int         FIDX_W     = 2;
    localparam logic [6:0] HOUR24_MAX = 7'd23;
    localparam logic [6:0] HOUR12_MAX = 7'd12;
    localparam logic [6:0] MINSEC_MAX = 7'd59;

    function automatic logic field_ok(input logic first, input logic mode12,
                                      input logic [3:0] tens, input logic [3:0] ones);
        logic [6:0] v;
        v = 7'(tens) * 7'd10 + 7'(ones);
        return first ? (mode12 ? (v >= 7'd1 && v <= HOUR12_MAX) : (v <= HOUR24_MAX))
                     : (v <= MINSEC_MAX);
    endfunction

    function automatic logic [3:0] onehot_digit(input logic [9:0] k);
        logic [3:0] d;
        d = '0;
        for (int i = 0; i < 10; i++) d = k[i] ? 4'(i) : d;
        return d;
    endfunction

endpackage

// File: rtl/bcd_field_reg.sv
// bcd_field_reg: one two-digit BCD working field with shift-in, clear and saturating digit count
module bcd_field_reg (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       shift_i,
    input  logic [3:0] digit_i,
    output logic [3:0] tens_o,
    output logic [3:0] ones_o,
    output logic [1:0] cnt_o
);

    logic [3:0] tens_q, ones_q;
    logic [1:0] cnt_q;

    // clear wins over shift; a shift moves ones into tens and counts up to two digits
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tens_q <= '0;
            ones_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            tens_q <= '0;
            ones_q <= '0;
            cnt_q  <= '0;
        end else if (shift_i) begin
            tens_q <= ones_q;
            ones_q <= digit_i;
            cnt_q  <= (cnt_q == 2'd2) ? 2'd2 : cnt_q + 2'd1;
        end
    end

    assign tens_o = tens_q;
    assign ones_o = ones_q;
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/field_time_entry.sv
// field_time_entry: keypad-driven BCD time entry with per-field validation, back/clear and inactivity abort
module field_time_entry
    import field_time_entry_pkg::*;
#(
    parameter int NUM_FIELDS     = 3,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    en,
    input  logic [9:0]              keypad,
    input  logic                    sharp,
    input  logic                    star,
    input  logic                    mode12,
    output logic                    busy,
    output logic [FIDX_W-1:0]       field_idx,
    output logic [NUM_FIELDS*8-1:0] time_out,
    output logic                    completeSetting,
    output logic                    error,
    output logic                    timeout
);

    localparam int TW = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e                  state_q, state_d;
    logic [FIDX_W-1:0]       idx_q, idx_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [NUM_FIELDS*8-1:0] time_q, packed_w;
    logic                    err_q, err_d, to_q, to_d, commit;
    logic [NUM_FIELDS-1:0]   clr, shift;
    logic [3:0]              tens [NUM_FIELDS];
    logic [3:0]              ones [NUM_FIELDS];
    logic [1:0]              cnt  [NUM_FIELDS];
    logic [3:0]              digit;
    logic                    key_ok, any_strobe, last;

    assign digit      = onehot_digit(keypad);
    assign key_ok     = (keypad != '0) && ((keypad & (keypad - 10'd1)) == '0);
    assign any_strobe = (keypad != '0) || sharp || star;
    assign last       = idx_q == FIDX_W'(NUM_FIELDS - 1);

    for (genvar f = 0; f < NUM_FIELDS; f++) begin : g_field
        bcd_field_reg u_reg (
            .clk_i   (clock),
            .rst_ni  (reset),
            .clr_i   (clr[f]),
            .shift_i (shift[f]),
            .digit_i (digit),
            .tens_o  (tens[f]),
            .ones_o  (ones[f]),
            .cnt_o   (cnt[f])
        );
    end

    // field 0 lands in the MSBs, tens nibble above ones nibble
    always_comb begin
        packed_w = '0;
        for (int f = 0; f < NUM_FIELDS; f++) packed_w[(NUM_FIELDS-1-f)*8 +: 8] = {tens[f], ones[f]};
    end

    // next state: star beats sharp beats keypad; the idle timer only fires on strobe-free cycles
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = '0;
        clr     = '0;
        shift   = '0;
        commit  = 1'b0;
        err_d   = 1'b0;
        to_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (en) begin
                    state_d = S_ENTRY;
                    clr     = '1;
                end
            end
            S_ENTRY: begin
                timer_d = any_strobe ? '0 : timer_q + 1'b1;
                if (star) begin
                    if (cnt[idx_q] != '0) begin
                        clr[idx_q] = 1'b1;
                    end else if (idx_q != '0) begin
                        idx_d              = idx_q - 1'b1;
                        clr[idx_q - 1'b1]  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (sharp) begin
                    if (!field_ok(idx_q == '0, mode12, tens[idx_q], ones[idx_q])) begin
                        err_d      = 1'b1;
                        clr[idx_q] = 1'b1;
                    end else if (last) begin
                        state_d = S_DONE;
                        commit  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (key_ok) begin
                    shift[idx_q] = 1'b1;
                end else if (!any_strobe && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    to_d    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        idx_d = (state_d == S_IDLE) ? '0 : idx_d;
    end

    // state, field index, idle timer, committed value and registered pulses
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            timer_q <= '0;
            time_q  <= '0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            time_q  <= commit ? packed_w : time_q;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    assign busy            = state_q != S_IDLE;
    assign field_idx       = idx_q;
    assign time_out        = time_q;
    assign completeSetting = state_q == S_DONE;
    assign error           = err_q;
    assign timeout         = to_q;

endmodule

// File: tb/tb_field_time_entry.sv
// tb_field_time_entry: scoreboard bench with a value-level reference model of time entry
module tb_field_time_entry;

    localparam int NF = 3;
    localparam int T  = 16;

    logic            clock = 1'b0, reset = 1'b0, en = 1'b0, sharp = 1'b0, star = 1'b0, mode12 = 1'b0;
    logic [9:0]      keypad = '0;
    logic            busy, completeSetting, error, timeout;
    logic [1:0]      field_idx;
    logic [NF*8-1:0] time_out;

    int checks = 0, errors = 0, cyc = 0;

    typedef struct {
        logic [2:0]      kind;
        logic [NF*8-1:0] val;
        int              cyc;
    } ev_t;
    ev_t exp_q[$];

    bit              m_busy, m_done;
    int              m_idx, m_idle;
    int              m_val [NF];
    int              m_cnt [NF];
    logic [NF*8-1:0] m_commit;

    field_time_entry #(.NUM_FIELDS(NF), .TIMEOUT_CYCLES(T)) dut (
        .clock           (clock),
        .reset           (reset),
        .en              (en),
        .keypad          (keypad),
        .sharp           (sharp),
        .star            (star),
        .mode12          (mode12),
        .busy            (busy),
        .field_idx       (field_idx),
        .time_out        (time_out),
        .completeSetting (completeSetting),
        .error           (error),
        .timeout         (timeout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h cycle=%0d", name, got, exp, cyc);
        end
    endtask

    // monitor: every pulse the DUT shows must match the oldest predicted event
    always @(negedge clock) begin
        if (reset && (completeSetting || error || timeout)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 32'({completeSetting, error, timeout}), 32'd0);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                chk("pulse_kind", 32'({completeSetting, error, timeout}), 32'(e.kind));
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
                if (e.kind == 3'b100) chk("commit_value", 32'(time_out), 32'(e.val));
            end
        end
    end

    function automatic logic [NF*8-1:0] pack_fields();
        logic [NF*8-1:0] p;
        p = '0;
        for (int f = 0; f < NF; f++) p[(NF-1-f)*8 +: 8] = {4'(m_val[f] / 10), 4'(m_val[f] % 10)};
        return p;
    endfunction

    task automatic m_clear(input int f);
        m_val[f] = 0;
        m_cnt[f] = 0;
    endtask

    task automatic m_reset();
        m_busy = 0; m_done = 0; m_idx = 0; m_idle = 0; m_commit = '0;
        for (int f = 0; f < NF; f++) m_clear(f);
    endtask

    // reference: each field is an integer 0..99, new digits push the old ones digit up
    task automatic model(input bit e, input logic [9:0] k, input bit sh, input bit st);
        bit strobe, ok;
        int v, dig;
        strobe = (k != 0) || sh || st;
        if (m_done) begin
            m_done = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (e) begin
                m_busy = 1; m_idx = 0; m_idle = 0;
                for (int f = 0; f < NF; f++) m_clear(f);
            end
        end else begin
            if (st) begin
                if (m_cnt[m_idx] > 0) m_clear(m_idx);
                else if (m_idx > 0) begin m_idx--; m_clear(m_idx); end
                else m_busy = 0;
            end else if (sh) begin
                v  = m_val[m_idx];
                ok = (m_idx == 0) ? (mode12 ? (v >= 1 && v <= 12) : (v <= 23)) : (v <= 59);
                if (!ok) begin
                    exp_q.push_back('{3'b010, m_commit, cyc});
                    m_clear(m_idx);
                end else if (m_idx == NF - 1) begin
                    m_done   = 1;
                    m_commit = pack_fields();
                    exp_q.push_back('{3'b100, m_commit, cyc});
                end else begin
                    m_idx++;
                end
            end else if ($countones(k) == 1) begin
                dig = 0;
                for (int d = 0; d < 10; d++) if (k[d]) dig = d;
                m_val[m_idx] = (m_val[m_idx] % 10) * 10 + dig;
                m_cnt[m_idx] = (m_cnt[m_idx] < 2) ? m_cnt[m_idx] + 1 : 2;
            end else if (!strobe && m_idle == T - 1) begin
                m_busy = 0;
                exp_q.push_back('{3'b001, m_commit, cyc});
            end
            m_idle = strobe ? 0 : m_idle + 1;
        end
        if (!m_busy) m_idx = 0;
    endtask

    task automatic step(input bit e, input logic [9:0] k, input bit sh, input bit st);
        en = e; keypad = k; sharp = sh; star = st;
        @(posedge clock);
        #1;
        en = 0; keypad = '0; sharp = 0; star = 0;
        model(e, k, sh, st);
        chk("busy", 32'(busy), 32'(m_busy));
        chk("field_idx", 32'(field_idx), 32'(m_idx));
        chk("time_out", 32'(time_out), 32'(m_commit));
    endtask

    task automatic key(input int d);
        step(0, 10'(1 << d), 0, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, '0, 0, 0);
    endtask

    initial begin
        int r;
        m_reset();
        #2;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_field_idx", 32'(field_idx), 0);
        chk("rst_time_out", 32'(time_out), 0);
        chk("rst_pulses", 32'({completeSetting, error, timeout}), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // full entry 14:30:25
        mode12 = 0;
        step(1, '0, 0, 0);
        key(1); key(4); step(0, '0, 1, 0);
        key(3); key(0); step(0, '0, 1, 0);
        key(2); key(5); step(0, '0, 1, 0);
        chk("done_pulse", 32'(completeSetting), 1);
        chk("commit_143025", 32'(time_out), 32'h143025);
        idle(1);

        // 12-hour rejection, then 09 accepted
        step(1, '0, 0, 0);
        mode12 = 1;
        key(1); key(3); step(0, '0, 1, 0);
        chk("err_13_mode12", 32'(error), 1);
        chk("idx_after_err", 32'(field_idx), 0);
        key(0); key(9); step(0, '0, 1, 0);
        chk("idx_after_09", 32'(field_idx), 1);
        key(7); step(0, '0, 1, 0);
        chk("idx_after_07", 32'(field_idx), 2);
        step(0, '0, 0, 1);
        chk("star_back", 32'(field_idx), 1);
        step(0, '0, 1, 0);
        chk("cleared_field_00", 32'(field_idx), 2);
        step(0, '0, 0, 1); step(0, '0, 0, 1); step(0, '0, 0, 1);
        chk("star_abort", 32'(busy), 0);

        // coincident strobes
        mode12 = 0;
        step(1, '0, 0, 0);
        key(2); step(0, 10'(1 << 9), 1, 0);
        chk("sharp_over_key", 32'(field_idx), 1);
        key(5); step(0, '0, 1, 1);
        chk("star_over_sharp", 32'(field_idx), 1);
        step(0, '0, 1, 0);
        key(5); key(9); step(0, '0, 1, 0);
        chk("commit_020059", 32'(time_out), 32'h020059);
        idle(1);

        // inactivity abort keeps the previous commit
        step(1, '0, 0, 0);
        idle(T);
        chk("timeout_pulse", 32'(timeout), 1);
        chk("timeout_busy", 32'(busy), 0);
        chk("timeout_keeps", 32'(time_out), 32'h020059);

        // reset in the middle of field 1
        step(1, '0, 0, 0);
        key(1); key(2); step(0, '0, 1, 0); key(3);
        reset = 1'b0;
        #2;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_time_out", 32'(time_out), 0);
        chk("midrst_field_idx", 32'(field_idx), 0);
        m_reset();
        #5 reset = 1'b1;
        key(4); step(0, '0, 1, 0); idle(2);

        // randomized sessions
        for (int i = 0; i < 700; i++) begin
            r = $urandom_range(0, 19);
            if ($urandom_range(0, 15) == 0) mode12 = ~mode12;
            if (!m_busy) step(1'($urandom_range(0, 1)), (r < 5) ? 10'(1 << r) : '0, r == 5, r == 6);
            else if (r < 10) key((r < 7) ? $urandom_range(0, 5) : $urandom_range(0, 9));
            else if (r < 14) step(0, '0, 1, 0);
            else if (r == 14) step(0, '0, 0, 1);
            else if (r == 15) step(0, 10'($urandom) | 10'b11, 0, 0);
            else if (r == 16) step(0, 10'(1 << $urandom_range(0, 9)), 1, 1'($urandom_range(0, 1)));
            else if (r == 17) idle($urandom_range(1, 18));
            else idle(1);
        end

        idle(3);
        chk("pending_events", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
